branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage consumer of the branch comparator's BrEq/BrLT flags; drives the comparator's BrUn select.
- Decodes the branch condition from funct3 and resolves the taken/not-taken outcome.
- Detects mispredictions against a BHT of 2-bit saturating counters that it owns. The IF stage reads that BHT through a lookup port.
- On a mispredict, issues a registered PC redirect and holds a multi-cycle front-end flush.

Parameters:
- BHT_ENTRIES, 16, number of 2-bit counters (power of 2, 4..256); index = pc[log2(BHT_ENTRIES)+1:2].
- FLUSH_CYCLES, 2, cycles flush stays high after a redirect (1..7).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- if_pc  input  32  IF-stage PC for BHT lookup.
- if_pred_taken  output  1  prediction for if_pc; combinational read, equals counter bit 1.
- ex_valid  input  1  EX holds a real instruction.
- ex_stall  input  1  EX held this cycle; no resolution.
- ex_is_branch  input  1  conditional branch in EX.
- ex_is_jump  input  1  JAL/JALR in EX; always taken.
- ex_funct3  input  3  branch funct3.
- ex_pred_taken  input  1  prediction carried down the pipe with the instruction.
- ex_pc  input  32  PC of the EX instruction.
- ex_target  input  32  computed branch/jump target.
- BrEq  input  1  from comparator.
- BrLT  input  1  from comparator.
- BrUn  output  1  to comparator; combinational.
- redirect  output  1  registered one-cycle pulse: front end must load redirect_pc.
- redirect_pc  output  32  registered corrected PC.
- flush  output  1  registered; squash IF/ID contents.
- illegal_br  output  1  registered one-cycle pulse: branch with funct3 010/011.
- br_count  output  32  resolved branches+jumps, wrapping.
- mispred_count  output  32  mispredicts, wrapping.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values:
  - redirect, flush and illegal_br = 0; redirect_pc = 0.
  - Both counts = 0; flush counter = 0.
  - All BHT entries = 2'b01 (weakly not-taken).
  - Reset asserted mid-flush or mid-redirect clears everything on that edge.
- BrUn: equals ex_funct3[1] when ex_is_branch=1, else 0.
- Condition decode, by funct3:
  - 000 taken = BrEq.
  - 001 taken = !BrEq.
  - 100 and 110 taken = BrLT.
  - 101 and 111 taken = !BrLT.
  - 010 and 011 taken = 0, and the illegal_br pulse fires on the next cycle.
- Resolution condition: resolve = ex_valid & !ex_stall & (ex_is_branch | ex_is_jump) & (flush_cnt == 0).
- Wrong-path instructions: instructions arriving during the flush window are ignored entirely, with no counting, no BHT update and no redirect.
- If ex_is_branch and ex_is_jump are both high, the jump wins: taken=1 and there is no BHT update.
- Actual outcome: actual = ex_is_jump | (ex_is_branch & cond).
- Misprediction: mispredict = resolve & (actual != ex_pred_taken).
- On the edge after a mispredict:
  - redirect = 1 for exactly one cycle.
  - redirect_pc = actual ? ex_target : ex_pc + 4, using 32-bit wrap (ex_pc = FFFFFFFC gives 00000000).
  - flush_cnt loads FLUSH_CYCLES.
- flush: flush = (flush_cnt != 0), registered; flush rises on the same cycle as redirect.
- flush_cnt decrements every cycle while nonzero, including during ex_stall.
- redirect_pc holds its last value when redirect=0.
- Counts: on resolve, br_count increments by 1. On mispredict, mispred_count also increments by 1. Both wrap at 2^32.
- BHT update: on resolve & ex_is_branch & funct3 legal, the counter at index(ex_pc) updates at the clock edge. Taken increments, saturating at 11; not-taken decrements, saturating at 00.
- BHT read: if_pred_taken reads pre-edge contents. Same-cycle read and update to the same index returns the old value.
- BHT storage: register array, not a synchronous RAM, so that the lookup stays combinational.
- Latency:
  - Resolution is combinational in EX.
  - redirect, flush and counts appear 1 cycle after the resolving cycle.
  - The BHT change is visible to if_pred_taken on the cycle after the update.

Test Plan:
- After reset, if_pc=0x00000040 → if_pred_taken=0; all outputs 0.
- BEQ, funct3=000, BrEq=1, pred=0, ex_pc=0x100, target=0x180 → next cycle redirect=1, redirect_pc=0x180, flush=1 for 2 cycles, mispred_count=1. BHT[0] goes to 10, so if_pc=0x100 predicts 1.
- BGEU, funct3=111 → BrUn=1. With BrLT=0 and pred=1 → no redirect, br_count increments, BHT saturates toward 11.
- Second mispredicting branch presented on the cycle flush is high → ignored: no second redirect, counts unchanged.
- BLT not-taken mispredict with ex_pc=0xFFFFFFFC, pred=1 → redirect_pc=0x00000000.
- funct3=010 with ex_is_branch → illegal_br pulse. Treated as not-taken: a redirect follows only if pred=1; no BHT update.
- rst asserted during flush_cnt=1 → flush=0 and counts=0 on the next cycle; every BHT entry reads back 01.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: condition decode, misprediction detection against
// an owned 2-bit-counter BHT, registered PC redirect and multi-cycle front-end flush.

module bht_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       upd,
    input  logic       taken,
    output logic [1:0] ctr
);
    always_ff @(posedge clk) begin
        if (rst)
            ctr <= 2'b01;
        else if (upd) begin
            if (taken && ctr != 2'b11)
                ctr <= ctr + 2'd1;
            else if (!taken && ctr != 2'b00)
                ctr <= ctr - 2'd1;
        end
    end
endmodule

module branch_resolve_unit #(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        BrEq,
    input  logic        BrLT,
    output logic        BrUn,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        illegal_br,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    logic [BHT_ENTRIES-1:0][1:0] bht;
    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [2:0]  flush_cnt, flush_cnt_nxt;
    logic        cond, f3_illegal, resolve, actual, mispredict, bht_upd;
    logic        unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Lookup reads the flops directly, so a same-edge update is not forwarded.
    assign if_pred_taken = bht[if_idx][1];

    assign BrUn = ex_is_branch ? ex_funct3[1] : 1'b0;

    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:          cond = BrEq;
            3'b001:          cond = !BrEq;
            3'b100, 3'b110:  cond = BrLT;
            3'b101, 3'b111:  cond = !BrLT;
            default:         cond = 1'b0;
        endcase
    end

    assign f3_illegal = (ex_funct3[2:1] == 2'b01);
    assign resolve    = ex_valid && !ex_stall && (ex_is_branch || ex_is_jump) && (flush_cnt == 3'd0);
    assign actual     = ex_is_jump || (ex_is_branch && cond);
    assign mispredict = resolve && (actual != ex_pred_taken);
    // Jumps never train the BHT, even when the branch flag is also set.
    assign bht_upd    = resolve && ex_is_branch && !ex_is_jump && !f3_illegal;

    genvar g;
    generate
        for (g = 0; g < BHT_ENTRIES; g++) begin : g_bht
            bht_ctr u_ctr (
                .clk   (clk),
                .rst   (rst),
                .upd   (bht_upd && (ex_idx == IDX_W'(g))),
                .taken (cond),
                .ctr   (bht[g])
            );
        end
    endgenerate

    always_comb begin
        flush_cnt_nxt = flush_cnt;
        if (mispredict)
            flush_cnt_nxt = FLUSH_INIT;
        else if (flush_cnt != 3'd0)
            flush_cnt_nxt = flush_cnt - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect      <= 1'b0;
            redirect_pc   <= 32'd0;
            flush_cnt     <= 3'd0;
            flush         <= 1'b0;
            illegal_br    <= 1'b0;
            br_count      <= 32'd0;
            mispred_count <= 32'd0;
        end else begin
            redirect   <= mispredict;
            flush_cnt  <= flush_cnt_nxt;
            flush      <= (flush_cnt_nxt != 3'd0);
            illegal_br <= resolve && ex_is_branch && f3_illegal;
            if (mispredict) begin
                redirect_pc   <= actual ? ex_target : ex_pc + 32'd4;
                mispred_count <= mispred_count + 32'd1;
            end
            if (resolve)
                br_count <= br_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table with a scoreboard
// queue, plus hand sequences for wrong-path, stall, saturation and reset.

module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, ex_stall, ex_is_branch, ex_is_jump;
    logic [2:0]  ex_funct3;
    logic        ex_pred_taken;
    logic [31:0] ex_pc, ex_target;
    logic        BrEq, BrLT, BrUn;
    logic        redirect, flush, illegal_br;
    logic [31:0] redirect_pc, br_count, mispred_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.BHT_ENTRIES(16), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_pred_taken(ex_pred_taken),
        .ex_pc(ex_pc), .ex_target(ex_target), .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .illegal_br(illegal_br), .br_count(br_count), .mispred_count(mispred_count)
    );

    typedef struct {
        logic        br, jmp;
        logic [2:0]  f3;
        logic        eq, lt, pred;
        logic [31:0] pc, tgt;
        logic        exp_brun, exp_redir;
        logic [31:0] exp_rpc;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        ill;
        logic        flush;
        logic [31:0] brc, misc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic [31:0] exp_br = 0, exp_mis = 0, exp_rpc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jump = 0;
        ex_funct3 = 3'b000; ex_pred_taken = 0; BrEq = 0; BrLT = 0;
        ex_pc = 0; ex_target = 0;
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic eq, input logic lt,
                            input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid = 1; ex_stall = 0; ex_is_branch = 1; ex_is_jump = 0;
        ex_funct3 = f3; BrEq = eq; BrLT = lt; ex_pred_taken = pred;
        ex_pc = pc; ex_target = tgt;
    endtask

    task automatic pred_chk(input string name, input logic [31:0] pc, input logic exp);
        @(negedge clk);
        if_pc = pc;
        #1 chk(name, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    task automatic apply(input vec_t v, input int n);
        exp_t e;
        @(negedge clk);
        ex_valid = 1; ex_stall = 0; ex_is_branch = v.br; ex_is_jump = v.jmp;
        ex_funct3 = v.f3; BrEq = v.eq; BrLT = v.lt; ex_pred_taken = v.pred;
        ex_pc = v.pc; ex_target = v.tgt;
        #1 chk($sformatf("brun[%0d]", n), {31'd0, BrUn}, {31'd0, v.exp_brun});
        exp_br++;
        if (v.exp_redir) begin
            exp_mis++;
            exp_rpc = v.exp_rpc;
        end
        sb.push_back('{v.exp_redir, exp_rpc, v.exp_ill, v.exp_redir, exp_br, exp_mis});
        @(posedge clk); #1;
        idle();
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard[%0d]: queue empty", n);
        end else begin
            e = sb.pop_front();
            chk($sformatf("redirect[%0d]", n), {31'd0, redirect}, {31'd0, e.redir});
            chk($sformatf("redirect_pc[%0d]", n), redirect_pc, e.rpc);
            chk($sformatf("illegal_br[%0d]", n), {31'd0, illegal_br}, {31'd0, e.ill});
            chk($sformatf("flush1[%0d]", n), {31'd0, flush}, {31'd0, e.flush});
            chk($sformatf("br_count[%0d]", n), br_count, e.brc);
            chk($sformatf("mispred_count[%0d]", n), mispred_count, e.misc);
        end
        @(posedge clk); #1;
        chk($sformatf("redirect_pulse[%0d]", n), {31'd0, redirect}, 32'd0);
        chk($sformatf("illegal_pulse[%0d]", n), {31'd0, illegal_br}, 32'd0);
        chk($sformatf("flush2[%0d]", n), {31'd0, flush}, {31'd0, v.exp_redir});
        @(posedge clk); #1;
        chk($sformatf("flush3[%0d]", n), {31'd0, flush}, 32'd0);
    endtask

    initial begin
        // br jmp f3 eq lt pred pc tgt | brun redir rpc ill
        vecs.push_back('{1,0,3'b000,1,0,0,32'h100,32'h180,      0,1,32'h180,0}); // BEQ taken, mispred
        vecs.push_back('{1,0,3'b111,0,0,1,32'h104,32'h200,      1,0,32'h0,  0}); // BGEU taken, correct
        vecs.push_back('{1,0,3'b001,1,0,0,32'h108,32'h280,      0,0,32'h0,  0}); // BNE not taken
        vecs.push_back('{1,0,3'b100,0,0,1,32'hFFFFFFFC,32'h40,  0,1,32'h0,  0}); // BLT wrap
        vecs.push_back('{1,0,3'b110,0,1,0,32'h10C,32'h300,      1,1,32'h300,0}); // BLTU taken
        vecs.push_back('{1,0,3'b101,0,1,1,32'h110,32'h400,      0,1,32'h114,0}); // BGE not taken
        vecs.push_back('{1,0,3'b010,1,1,1,32'h100,32'h500,      1,1,32'h104,1}); // illegal, pred=1
        vecs.push_back('{1,0,3'b011,1,1,0,32'h118,32'h580,      1,0,32'h0,  1}); // illegal, pred=0
        vecs.push_back('{0,1,3'b000,0,0,0,32'h11C,32'h600,      0,1,32'h600,0}); // JAL
        vecs.push_back('{1,1,3'b110,0,0,1,32'h120,32'h700,      1,0,32'h0,  0}); // jump wins
        vecs.push_back('{1,0,3'b111,0,0,1,32'h104,32'h200,      1,0,32'h0,  0}); // BGEU 10->11
        vecs.push_back('{1,0,3'b111,0,0,1,32'h104,32'h200,      1,0,32'h0,  0}); // BGEU stays 11
        vecs.push_back('{1,0,3'b111,0,1,1,32'h104,32'h200,      1,1,32'h108,0}); // 11->10, mispred

        idle();
        if_pc = 32'h40;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_pred", {31'd0, if_pred_taken}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_br}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_brc", br_count, 32'd0);
        chk("rst_misc", mispred_count, 32'd0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        pred_chk("bht_0x100", 32'h100, 1'b1);       // illegal did not train it down
        pred_chk("bht_0x104", 32'h104, 1'b1);       // saturated, then one decrement
        pred_chk("bht_0x108", 32'h108, 1'b0);
        pred_chk("bht_0xFFC", 32'hFFFFFFFC, 1'b0);
        pred_chk("bht_0x10C", 32'h10C, 1'b1);
        pred_chk("bht_0x110", 32'h110, 1'b0);
        pred_chk("bht_0x120", 32'h120, 1'b0);       // jump+branch did not train

        // Wrong-path branch held across the flush window
        @(negedge clk);
        drive_br(3'b000, 1, 0, 0, 32'h124, 32'h800);
        exp_br++; exp_mis++; exp_rpc = 32'h800;
        @(posedge clk); #1;
        chk("wp_redirect", {31'd0, redirect}, 32'd1);
        chk("wp_rpc", redirect_pc, 32'h800);
        chk("wp_flush", {31'd0, flush}, 32'd1);
        drive_br(3'b000, 1, 0, 0, 32'h128, 32'h900);
        @(posedge clk); #1;
        chk("wp_no_redirect1", {31'd0, redirect}, 32'd0);
        chk("wp_rpc_hold", redirect_pc, 32'h800);
        chk("wp_brc1", br_count, exp_br);
        @(posedge clk); #1;
        idle();
        chk("wp_no_redirect2", {31'd0, redirect}, 32'd0);
        chk("wp_flush_end", {31'd0, flush}, 32'd0);
        chk("wp_brc2", br_count, exp_br);
        chk("wp_misc", mispred_count, exp_mis);
        pred_chk("wp_bht_0x124", 32'h124, 1'b1);
        pred_chk("wp_bht_0x128", 32'h128, 1'b0);

        // Stalled EX never resolves
        @(negedge clk);
        drive_br(3'b000, 1, 0, 0, 32'h12C, 32'hA00);
        ex_stall = 1;
        @(posedge clk); #1;
        idle();
        chk("stall_redirect", {31'd0, redirect}, 32'd0);
        chk("stall_brc", br_count, exp_br);
        pred_chk("stall_bht", 32'h12C, 1'b0);

        // Reset in the last flush cycle
        @(negedge clk);
        drive_br(3'b000, 1, 0, 0, 32'h130, 32'hB00);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        chk("pre_rst_flush", {31'd0, flush}, 32'd1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("mid_rst_flush", {31'd0, flush}, 32'd0);
        chk("mid_rst_redirect", {31'd0, redirect}, 32'd0);
        chk("mid_rst_rpc", redirect_pc, 32'd0);
        chk("mid_rst_brc", br_count, 32'd0);
        chk("mid_rst_misc", mispred_count, 32'd0);
        for (int i = 0; i < 16; i++)
            pred_chk($sformatf("mid_rst_bht[%0d]", i), 32'(i) << 2, 1'b0);
        // One taken step from 01 must reach a taken prediction
        @(negedge clk);
        drive_br(3'b000, 1, 0, 0, 32'h0, 32'hC00);
        @(posedge clk); #1;
        idle();
        chk("post_rst_redirect", {31'd0, redirect}, 32'd1);
        chk("post_rst_brc", br_count, 32'd1);
        pred_chk("post_rst_bht0", 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
